// File: rtl/mem_block_mover.sv
// Purpose: word-granular block copy/fill initiator for the byte-addressable data memory.
// Latency: copy of N words is 2N busy cycles, fill is N cycles, then a one-cycle done pulse.
// Backpressure: none; memory is always ready, start is ignored unless idle, abort cancels at once.
module mem_block_mover #(
    parameter int BYTE_SIZE  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      mode,
    input  logic [ADDR_WIDTH-1:0]     src_addr,
    input  logic [ADDR_WIDTH-1:0]     dst_addr,
    input  logic [LEN_WIDTH-1:0]      len,
    input  logic [BYTE_SIZE*8-1:0]    fill_data,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic                      mem_we,
    output logic [BYTE_SIZE*8-1:0]    mem_wd,
    input  logic [BYTE_SIZE*8-1:0]    mem_rd
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BYTE_SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   src_ptr;
    logic [ADDR_WIDTH-1:0]   dst_ptr;
    logic [LEN_WIDTH-1:0]    count;
    logic [BYTE_SIZE*8-1:0]  fill_reg;
    logic                    fill_mode;
    logic                    we_reg;

    // Abort must suppress the write in the very cycle it is seen, so the
    // enable is the only output with a combinational term.
    assign mem_we = we_reg & ~abort;

    // Transfer sequencer; every output is registered as the value for the
    // state being entered. mem_wd doubles as the copy data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            count     <= '0;
            fill_reg  <= '0;
            fill_mode <= 1'b0;
            we_reg    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            mem_wd    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            src_ptr   <= src_addr;
                            dst_ptr   <= dst_addr;
                            count     <= len;
                            fill_reg  <= fill_data;
                            fill_mode <= mode;
                            busy      <= 1'b1;
                            if (mode) begin
                                state    <= WRITE;
                                mem_addr <= dst_addr;
                                mem_wd   <= fill_data;
                                we_reg   <= 1'b1;
                            end else begin
                                state    <= READ;
                                mem_addr <= src_addr;
                            end
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (abort) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        mem_addr <= '0;
                        mem_wd   <= '0;
                    end else begin
                        state    <= WRITE;
                        mem_wd   <= mem_rd;
                        mem_addr <= dst_ptr;
                        we_reg   <= 1'b1;
                    end
                end
                WRITE: begin
                    if (abort) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        we_reg   <= 1'b0;
                        mem_addr <= '0;
                        mem_wd   <= '0;
                    end else begin
                        src_ptr <= src_ptr + STEP;
                        dst_ptr <= dst_ptr + STEP;
                        count   <= count - LEN_WIDTH'(1);
                        if (count == LEN_WIDTH'(1)) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            we_reg   <= 1'b0;
                            mem_addr <= '0;
                            mem_wd   <= '0;
                        end else if (fill_mode) begin
                            mem_addr <= dst_ptr + STEP;
                            mem_wd   <= fill_reg;
                        end else begin
                            state    <= READ;
                            we_reg   <= 1'b0;
                            mem_addr <= src_ptr + STEP;
                            mem_wd   <= '0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_block_mover.sv
// Purpose: self-checking bench for mem_block_mover against a byte memory and a reference copy.
// Latency: checks busy-cycle counts and done-pulse cycle for each table entry.
// Backpressure: none in the DUT; abort and start-while-busy are exercised explicitly.
module tb_mem_block_mover;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [7:0]  len;
    logic [31:0] fill_data;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int total = 0;
    int bad   = 0;

    mem_block_mover #(.BYTE_SIZE(4), .ADDR_WIDTH(32), .LEN_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
        .abort(abort), .busy(busy), .done(done), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // 4 KiB byte memory aliased across the address space (low 12 bits).
    logic [7:0]  mem [4096];
    logic [11:0] ma;
    logic        tb_clr;
    logic        tb_we;
    logic [11:0] tb_addr;
    logic [31:0] tb_wd;

    assign ma     = mem_addr[11:0];
    assign mem_rd = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};

    // Synchronous write port shared by the DUT and the bench preload path.
    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++) mem[ma + 12'(b)] <= mem_wd[8*b +: 8];
        end else if (tb_we) begin
            for (int b = 0; b < 4; b++) mem[tb_addr + 12'(b)] <= tb_wd[8*b +: 8];
        end
    end

    // Reference memory, updated by the bench in transfer order.
    logic [7:0] ref_mem [4096];

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [11:0] x;
        x = a[11:0];
        return {mem[x + 12'd3], mem[x + 12'd2], mem[x + 12'd1], mem[x]};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [11:0] x;
        x = a[11:0];
        return {ref_mem[x + 12'd3], ref_mem[x + 12'd2], ref_mem[x + 12'd1], ref_mem[x]};
    endfunction

    task automatic ref_wr(input logic [31:0] a, input logic [31:0] d);
        logic [11:0] x;
        x = a[11:0];
        for (int b = 0; b < 4; b++) ref_mem[x + 12'(b)] = d[8*b +: 8];
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_we   = 1'b1;
        tb_addr = a[11:0];
        tb_wd   = d;
        ref_wr(a, d);
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t sbq[$];

    typedef struct {
        logic        mode;
        logic [31:0] src;
        logic [31:0] dst;
        logic [7:0]  len;
        logic [31:0] fill;
        int          abort_at;
        logic        hold;
        int          exp_busy;
        int          exp_done;
    } vec_t;

    vec_t tbl [7];

    task automatic run(input vec_t v);
        int busy_n  = 0;
        int done_n  = 0;
        int done_at = 0;
        int nw;
        wr_t w;
        nw = int'(v.len);
        if (v.abort_at != 0) nw = v.mode ? v.abort_at - 1 : (v.abort_at - 1) / 2;
        if (nw > int'(v.len)) nw = int'(v.len);
        // Scoreboard: expected writes in order, applied to the reference memory.
        for (int i = 0; i < nw; i++) begin
            w.addr = v.dst + 32'(4 * i);
            w.data = v.mode ? v.fill : ref_rd(v.src + 32'(4 * i));
            ref_wr(w.addr, w.data);
            sbq.push_back(w);
        end
        @(negedge clk);
        start     = 1'b1;
        mode      = v.mode;
        src_addr  = v.src;
        dst_addr  = v.dst;
        len       = v.len;
        fill_data = v.fill;
        for (int c = 1; c <= 2 * int'(v.len) + 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start     = v.hold;
                mode      = ~v.mode;
                src_addr  = $urandom;
                dst_addr  = $urandom;
                len       = 8'($urandom_range(1, 255));
                fill_data = $urandom;
            end
            if (v.abort_at != 0 && c == v.abort_at) begin
                abort = 1'b1;
                start = 1'b0;
            end else begin
                abort = 1'b0;
            end
            #1;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_at = c;
            end
            if (mem_we) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr %h data %h, no write expected", mem_addr, mem_wd);
                end else begin
                    w = sbq.pop_front();
                    chk("wr_addr", mem_addr, w.addr);
                    chk("wr_data", mem_wd, w.data);
                end
            end
        end
        abort = 1'b0;
        start = 1'b0;
        chk("busy_cycles", 32'(busy_n), 32'(v.exp_busy));
        chk("done_pulses", 32'(done_n), (v.exp_done != 0) ? 32'd1 : 32'd0);
        chk("done_cycle", 32'(done_at), 32'(v.exp_done));
        chk("missing_writes", 32'(sbq.size()), 32'd0);
        sbq.delete();
        for (int i = 0; i < int'(v.len); i++)
            chk("mem_word", rd_word(v.dst + 32'(4 * i)), ref_rd(v.dst + 32'(4 * i)));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        len = '0; fill_data = '0; abort = 1'b0;
        tb_clr = 1'b1; tb_we = 1'b0; tb_addr = '0; tb_wd = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;

        //          mode  src           dst           len   fill          ab  hold busy done
        tbl[0] = '{1'b0, 32'h0000_0000, 32'h0000_0040, 8'd3, 32'h0,        0, 1'b0, 6, 7};
        tbl[1] = '{1'b1, 32'h0000_0000, 32'h0000_0080, 8'd4, 32'hDEADBEEF, 0, 1'b0, 4, 5};
        tbl[2] = '{1'b1, 32'h0000_0000, 32'h0000_0200, 8'd0, 32'h12345678, 0, 1'b0, 0, 1};
        tbl[3] = '{1'b1, 32'h0000_0000, 32'h0000_00C0, 8'd5, 32'h5A5A5A5A, 3, 1'b1, 3, 0};
        tbl[4] = '{1'b0, 32'h0000_0000, 32'h0000_0004, 8'd3, 32'h0,        0, 1'b0, 6, 7};
        tbl[5] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 8'd2, 32'hCAFEF00D, 0, 1'b0, 2, 3};
        tbl[6] = '{1'b0, 32'h0000_0084, 32'h0000_0300, 8'd1, 32'h0,        0, 1'b0, 2, 3};

        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wd", mem_wd, 32'd0);
        rst_n  = 1'b1;
        tb_clr = 1'b0;

        preload(32'h0, 32'h11111111);
        preload(32'h4, 32'h22222222);
        preload(32'h8, 32'h33333333);
        preload(32'h100, 32'hA5A5A5A5);

        // Reset asserted in the first WRITE cycle of a copy.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; src_addr = 32'h0; dst_addr = 32'h100; len = 8'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        chk("pre_rst_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(mem_we), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_keep", rd_word(32'h100), 32'hA5A5A5A5);

        for (int t = 0; t < 7; t++) begin
            run(tbl[t]);
            if (t == 4) begin
                chk("ovl_w1", rd_word(32'h4), 32'h11111111);
                chk("ovl_w2", rd_word(32'h8), 32'h11111111);
                chk("ovl_w3", rd_word(32'hC), 32'h11111111);
            end
        end
        chk("wrap_lo", rd_word(32'h0), 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_block_mover.md
Name: mem_block_mover

Overview:
- Bus initiator for the team's byte-addressable single-port data memory (combinational read, synchronous write, little-endian multi-byte words).
- Drives that memory's address, write-enable and write-data, and consumes its read data.
- Performs word-granular block copy (src→dst) or block fill (constant→dst) on a start pulse.
- Used for boot-time memory initialisation and testbench/data-section setup in the pipelined ARM computer.

Parameters:
- BYTE_SIZE, 4, bytes per word; mem_wd/mem_rd/fill_data width = BYTE_SIZE*8.
- ADDR_WIDTH, 32, byte-address width.
- LEN_WIDTH, 8, width of the word-count input.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill; latched on accepted start.
- src_addr  in  ADDR_WIDTH  copy source byte address; latched on start.
- dst_addr  in  ADDR_WIDTH  destination byte address; latched on start.
- len  in  LEN_WIDTH  number of words to move; latched on start.
- fill_data  in  BYTE_SIZE*8  fill word; latched on start.
- abort  in  1  cancels the active transfer.
- busy  out  1  high in READ/WRITE.
- done  out  1  one-cycle completion pulse.
- mem_addr  out  ADDR_WIDTH  memory byte address.
- mem_we  out  1  memory write enable.
- mem_wd  out  BYTE_SIZE*8  memory write data.
- mem_rd  in  BYTE_SIZE*8  memory read data (combinational from mem_addr).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State IDLE; pointers, count and data registers 0.
  - busy=0, done=0, mem_we=0, mem_addr=0, mem_wd=0.
  - mem_we falls asynchronously, so a write in flight is cancelled.
- States: IDLE, READ, WRITE, DONE.
- IDLE: outputs at reset values.
  - start=1, len≠0: latch all inputs. Next state READ (mode 0) or WRITE (mode 1).
  - start=1, len=0: next state DONE; no memory access.
- READ:
  - mem_addr=src_ptr, mem_we=0.
  - At clock edge: data_reg←mem_rd; next state WRITE.
- WRITE:
  - mem_addr=dst_ptr; mem_wd=data_reg (copy) or fill_reg (fill); mem_we=~abort.
  - At edge: src_ptr+=BYTE_SIZE, dst_ptr+=BYTE_SIZE, count-=1.
  - If count was 1, next state DONE. Otherwise READ (copy) or WRITE (fill).
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start is ignored here.
- abort:
  - Sampled in READ/WRITE; next state IDLE; no done pulse.
  - mem_we is combinationally gated off in the abort cycle, so no write occurs.
  - Ignored in IDLE/DONE.
- start while busy or in DONE is ignored; no queuing.
- Latency from the start edge:
  - Copy of N words: busy for 2N cycles, done in cycle 2N+1.
  - Fill of N words: busy for N cycles, done in cycle N+1.
  - len=0: done in cycle 1.
- Pointer arithmetic wraps modulo 2^ADDR_WIDTH. No alignment check: unaligned addresses are passed through.
- Overlapping copy: strictly ascending and word-sequential, read-before-write per word. With dst>src and overlap, already-written words propagate forward; this is defined behaviour.
- Input changes after an accepted start have no effect on the running transfer.

Test Plan:
- Reset mid-copy (assert rst_n=0 during a WRITE cycle) -> mem_we=0 immediately, busy=0, the targeted word keeps its old value, and a following start works normally.
- Preload mem[0..11]=words 0x11111111, 0x22222222, 0x33333333; copy src=0, dst=0x40, len=3 -> mem[0x40..0x4B] match with the same byte order; busy for 6 cycles; single done pulse in cycle 7.
- Fill dst=0x80, len=4, fill_data=0xDEADBEEF -> four words written on consecutive cycles, mem_addr=0x80, 0x84, 0x88, 0x8C; done in cycle 5.
- start with len=0 -> mem_we never asserted; done pulses the cycle after start; busy stays 0.
- Fill len=5 with abort=1 in the 3rd WRITE cycle -> exactly 2 words written, no done, returns to IDLE the next cycle; start held high during the transfer is ignored.
- dst=0xFFFFFFFC, len=2 fill -> second write at mem_addr=0x00000000 (wrap-around); overlapping copy src=0, dst=4, len=3 -> all destination words equal the original word 0.
